// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths and state encoding for the RAM port arbiter
package mem_port_arbiter_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int REG_W       = 32;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GIF  = 2'd1,
        ARB_GDM  = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_timeout_cnt.sv
// rtl/arb_timeout_cnt.sv - loadable up-counter with clear, enable and terminal-count flag
module arb_timeout_cnt #(
    parameter int CNT_W    = 5,
    parameter int TERMINAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(TERMINAL));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one RAM port between instruction fetch and MEM-stage load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_BURST_MAX = 4,
    parameter int TIMEOUT        = 16,
    parameter int CNT_W          = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req_i,
    input  logic [INST_ADDR_W-1:0] if_addr_i,
    output logic                   if_ack_o,
    output logic [INST_W-1:0]      if_data_o,
    input  logic                   dm_req_i,
    input  logic                   dm_we_i,
    input  logic [REG_W-1:0]       dm_addr_i,
    input  logic [3:0]             dm_sel_i,
    input  logic [REG_W-1:0]       dm_wdata_i,
    output logic                   dm_ack_o,
    output logic [REG_W-1:0]       dm_rdata_o,
    output logic                   ram_ce_o,
    output logic                   ram_we_o,
    output logic [REG_W-1:0]       ram_addr_o,
    output logic [3:0]             ram_sel_o,
    output logic [REG_W-1:0]       ram_data_o,
    input  logic [REG_W-1:0]       ram_data_i,
    input  logic                   ram_hit_i,
    output logic                   stall_req_o,
    output logic                   err_o
);

    localparam int                 BURST_W     = $clog2(DATA_BURST_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_MAX_V = BURST_W'(DATA_BURST_MAX);

    arb_state_e         state, state_next;
    logic [BURST_W-1:0] burst_cnt;
    logic               force_if;
    logic               grant_if, grant_dm;
    logic               finish, timed_out;
    logic               tmo_tc;
    logic               in_grant;
    logic [REG_W-1:0]   done_data;

    // Fetch jumps the queue only after a full run of data grants made while it waited.
    assign force_if  = if_req_i && (burst_cnt == BURST_MAX_V);
    assign in_grant  = (state == ARB_GIF) || (state == ARB_GDM);
    assign done_data = timed_out ? '0 : ram_data_i;

    assign stall_req_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        finish     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (dm_req_i && !force_if) begin
                    grant_dm   = 1'b1;
                    state_next = ARB_GDM;
                end else if (if_req_i) begin
                    grant_if   = 1'b1;
                    state_next = ARB_GIF;
                end
            end
            ARB_GIF, ARB_GDM: begin
                // A hit on the terminal cycle still counts as a normal completion.
                if (ram_hit_i) begin
                    finish     = 1'b1;
                    state_next = ARB_DONE;
                end else if (tmo_tc) begin
                    finish     = 1'b1;
                    timed_out  = 1'b1;
                    state_next = ARB_DONE;
                end
            end
            ARB_DONE: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    arb_timeout_cnt #(
        .CNT_W    (CNT_W),
        .TERMINAL (TIMEOUT - 1)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (finish),
        .load     (grant_if | grant_dm),
        .load_val ('0),
        .en       (in_grant && !finish),
        .tc       (tmo_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_ce_o   <= 1'b0;
            ram_we_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_sel_o  <= '0;
            ram_data_o <= '0;
            if_ack_o   <= 1'b0;
            if_data_o  <= '0;
            dm_ack_o   <= 1'b0;
            dm_rdata_o <= '0;
            err_o      <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            if_ack_o <= 1'b0;
            dm_ack_o <= 1'b0;

            if (grant_dm) begin
                ram_ce_o   <= 1'b1;
                ram_we_o   <= dm_we_i;
                ram_addr_o <= dm_addr_i;
                ram_sel_o  <= dm_sel_i;
                ram_data_o <= dm_wdata_i;
            end else if (grant_if) begin
                ram_ce_o   <= 1'b1;
                ram_we_o   <= 1'b0;
                ram_addr_o <= if_addr_i;
                ram_sel_o  <= SEL_ALL;
                ram_data_o <= '0;
            end

            if (finish) begin
                ram_ce_o <= 1'b0;
                if (state == ARB_GIF) begin
                    if_ack_o  <= 1'b1;
                    if_data_o <= done_data;
                end else begin
                    dm_ack_o   <= 1'b1;
                    dm_rdata_o <= done_data;
                end
                if (timed_out) begin
                    err_o <= 1'b1;
                end
            end

            if (grant_if) begin
                burst_cnt <= '0;
            end else if (grant_dm) begin
                if (!if_req_i) begin
                    burst_cnt <= '0;
                end else if (burst_cnt != BURST_MAX_V) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end
        end
    end

endmodule
